// File: rtl/ex_mem_flags_if.sv
// EX -> MEM bundle: execute-stage result/control in, registered MEM-stage copy out.
interface ex_mem_flags_if;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_result;
  logic        ex_ovf;
  logic [3:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic [15:0] ex_store_data;
  logic        mem_valid;
  logic        mem_regwrite;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [15:0] mem_result;
  logic [3:0]  mem_rd;
  logic [15:0] mem_store_data;

  modport master (
    output ex_valid, ex_opcode, ex_result, ex_ovf, ex_rd,
    output ex_regwrite, ex_memread, ex_memwrite, ex_store_data,
    input  mem_valid, mem_regwrite, mem_memread, mem_memwrite,
    input  mem_result, mem_rd, mem_store_data
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_result, ex_ovf, ex_rd,
    input  ex_regwrite, ex_memread, ex_memwrite, ex_store_data,
    output mem_valid, mem_regwrite, mem_memread, mem_memwrite,
    output mem_result, mem_rd, mem_store_data
  );
endinterface

// File: rtl/ex_mem_flags.sv
// EX/MEM pipeline register, Z/V/N flag register and branch evaluation.
// FLAG_BYPASS_EN: branches see next-state flags instead of registered ones.
module ex_mem_flags (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  ex_mem_flags_if.slave    bus,
  input  logic [2:0]       br_ccc,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  output logic             br_taken
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  logic op_zvn;
  logic op_z;
  logic upd;
  logic nz;
  logic nv;
  logic nn;
  logic src_z;
  logic src_v;
  logic src_n;

  always_comb begin
    op_zvn = 1'b0;
    op_z   = 1'b0;
    unique case (1'b1)
      (bus.ex_opcode == OP_ADD),
      (bus.ex_opcode == OP_SUB): op_zvn = 1'b1;
      (bus.ex_opcode == OP_XOR),
      (bus.ex_opcode == OP_SLL),
      (bus.ex_opcode == OP_SRA),
      (bus.ex_opcode == OP_ROR): op_z = 1'b1;
      default: ;
    endcase
  end

  assign upd = !rst && !flush && !stall && bus.ex_valid;
  assign nz  = (upd && (op_zvn || op_z)) ? (bus.ex_result == 16'h0000) : flag_z;
  assign nv  = (upd && op_zvn) ? bus.ex_ovf : flag_v;
  assign nn  = (upd && op_zvn) ? bus.ex_result[15] : flag_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_valid      <= 1'b0;
      bus.mem_regwrite   <= 1'b0;
      bus.mem_memread    <= 1'b0;
      bus.mem_memwrite   <= 1'b0;
      bus.mem_result     <= 16'h0000;
      bus.mem_rd         <= 4'h0;
      bus.mem_store_data <= 16'h0000;
      flag_z             <= 1'b0;
      flag_v             <= 1'b0;
      flag_n             <= 1'b0;
    end else begin
      // n* equal the registered flags unless a real capture updates them
      flag_z <= nz;
      flag_v <= nv;
      flag_n <= nn;
      if (flush) begin
        bus.mem_valid    <= 1'b0;
        bus.mem_regwrite <= 1'b0;
        bus.mem_memread  <= 1'b0;
        bus.mem_memwrite <= 1'b0;
      end else if (!stall) begin
        bus.mem_valid      <= bus.ex_valid;
        bus.mem_regwrite   <= bus.ex_valid & bus.ex_regwrite;
        bus.mem_memread    <= bus.ex_valid & bus.ex_memread;
        bus.mem_memwrite   <= bus.ex_valid & bus.ex_memwrite;
        bus.mem_result     <= bus.ex_result;
        bus.mem_rd         <= bus.ex_rd;
        bus.mem_store_data <= bus.ex_store_data;
      end
    end
  end

`ifdef FLAG_BYPASS_EN
  assign src_z = nz;
  assign src_v = nv;
  assign src_n = nn;
`else
  assign src_z = flag_z;
  assign src_v = flag_v;
  assign src_n = flag_n;
`endif

  always_comb begin
    br_taken = 1'b0;
    unique case (br_ccc)
      3'b000: br_taken = !src_z;
      3'b001: br_taken = src_z;
      3'b010: br_taken = !src_z && !src_n;
      3'b011: br_taken = src_n;
      3'b100: br_taken = src_z || !src_n;
      3'b101: br_taken = src_n || src_z;
      3'b110: br_taken = src_v;
      3'b111: br_taken = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ex_mem_flags.sv
// Self-checking bench for ex_mem_flags against a behavioural reference model.
module tb_ex_mem_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       flush;
  logic [2:0] br_ccc;
  logic       flag_z;
  logic       flag_v;
  logic       flag_n;
  logic       br_taken;

  int tests = 0;
  int fails = 0;

  ex_mem_flags_if bus ();

  ex_mem_flags dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .bus      (bus),
    .br_ccc   (br_ccc),
    .flag_z   (flag_z),
    .flag_v   (flag_v),
    .flag_n   (flag_n),
    .br_taken (br_taken)
  );

  always #5 clk = ~clk;

  // reference state
  logic        m_valid, m_rw, m_mr, m_mw;
  logic [15:0] m_res, m_sd;
  logic [3:0]  m_rd;
  logic        m_z, m_v, m_n;

  // 2: Z/V/N, 1: Z only, 0: none
  function automatic int flag_kind(input logic [3:0] op);
    case (op)
      4'd0, 4'd1:             return 2;
      4'd2, 4'd4, 4'd5, 4'd6: return 1;
      default:                return 0;
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] c,
                                  input logic z, input logic n, input logic v);
    case (c)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || !n;
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  // flags the branch should see this cycle
  function automatic logic [2:0] src_flags();
    logic z, v, n;
    int k;
    z = m_z; v = m_v; n = m_n;
`ifdef FLAG_BYPASS_EN
    k = flag_kind(bus.ex_opcode);
    if (!rst && !flush && !stall && bus.ex_valid && k != 0) begin
      z = (bus.ex_result == 16'h0000);
      if (k == 2) begin
        v = bus.ex_ovf;
        n = bus.ex_result[15];
      end
    end
`endif
    return {z, v, n};
  endfunction

  function automatic logic [42:0] pack_dut();
    return {bus.mem_valid, bus.mem_regwrite, bus.mem_memread, bus.mem_memwrite,
            bus.mem_result, bus.mem_rd, bus.mem_store_data,
            flag_z, flag_v, flag_n};
  endfunction

  function automatic logic [42:0] pack_model();
    return {m_valid, m_rw, m_mr, m_mw, m_res, m_rd, m_sd, m_z, m_v, m_n};
  endfunction

  task automatic model_edge();
    int k;
    k = flag_kind(bus.ex_opcode);
    if (rst) begin
      {m_valid, m_rw, m_mr, m_mw} = 4'b0;
      m_res = '0; m_rd = '0; m_sd = '0;
      {m_z, m_v, m_n} = 3'b0;
    end else if (flush) begin
      {m_valid, m_rw, m_mr, m_mw} = 4'b0;
    end else if (!stall) begin
      m_valid = bus.ex_valid;
      m_rw = bus.ex_valid ? bus.ex_regwrite : 1'b0;
      m_mr = bus.ex_valid ? bus.ex_memread : 1'b0;
      m_mw = bus.ex_valid ? bus.ex_memwrite : 1'b0;
      m_res = bus.ex_result;
      m_rd = bus.ex_rd;
      m_sd = bus.ex_store_data;
      if (bus.ex_valid && k != 0) begin
        m_z = (bus.ex_result == 16'h0000);
        if (k == 2) begin
          m_v = bus.ex_ovf;
          m_n = bus.ex_result[15];
        end
      end
    end
  endtask

  task automatic apply(input logic r, input logic s, input logic f,
                       input logic v, input logic [3:0] op,
                       input logic [15:0] res, input logic ovf,
                       input logic [3:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic [15:0] sd,
                       input logic [2:0] c);
    rst = r; stall = s; flush = f;
    bus.ex_valid = v; bus.ex_opcode = op; bus.ex_result = res;
    bus.ex_ovf = ovf; bus.ex_rd = rd; bus.ex_regwrite = rw;
    bus.ex_memread = mr; bus.ex_memwrite = mw; bus.ex_store_data = sd;
    br_ccc = c;
    #1;
  endtask

  task automatic idle(input logic [2:0] c);
    apply(0, 0, 0, 0, 4'hf, 16'($urandom), 0, 4'($urandom),
          1, 1, 1, 16'($urandom), c);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
            16'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 16'($urandom), 3'($urandom));
      tick();
    end
    tests++;
    if (pack_dut() !== 43'h0) begin
      fails++;
      $display("FAIL reset_state got=%h want=0", pack_dut());
    end
    idle(3'b111);
    tests++;
    if (br_taken !== 1'b1) begin
      fails++;
      $display("FAIL reset_br_unc got=%b want=1", br_taken);
    end
    br_ccc = 3'b000;
    #1;
    tests++;
    if (br_taken !== 1'b1) begin
      fails++;
      $display("FAIL reset_br_ne got=%b want=1", br_taken);
    end
  endtask

  task automatic test_add_flags();
    apply(0, 0, 0, 1, 4'b0000, 16'h8000, 1, 4'd3, 1, 0, 0, 16'h1111, 3'd7);
    tick();
    tests++;
    if ({flag_z, flag_n, flag_v, bus.mem_result} !== {3'b011, 16'h8000}) begin
      fails++;
      $display("FAIL add_flags got z%b n%b v%b res=%h want z0 n1 v1 res=8000",
               flag_z, flag_n, flag_v, bus.mem_result);
    end
    apply(0, 0, 0, 1, 4'b0100, 16'h0000, 0, 4'd4, 1, 0, 0, 16'h2222, 3'd7);
    tick();
    tests++;
    if ({flag_z, flag_n, flag_v} !== 3'b111) begin
      fails++;
      $display("FAIL sll_z_only got z%b n%b v%b want z1 n1 v1",
               flag_z, flag_n, flag_v);
    end
    tests++;
    if (pack_dut() !== pack_model()) begin
      fails++;
      $display("FAIL add_state got=%h want=%h", pack_dut(), pack_model());
    end
  endtask

  task automatic test_stall_flush();
    apply(0, 0, 0, 1, 4'b0000, 16'h1234, 0, 4'd5, 1, 0, 0, 16'h5555, 3'd7);
    tick();
    apply(0, 1, 0, 1, 4'b0001, 16'h0000, 1, 4'd6, 1, 1, 1, 16'h6666, 3'd7);
    tick();
    tests++;
    if ({flag_z, flag_v, flag_n, bus.mem_result, bus.mem_rd}
        !== {3'b000, 16'h1234, 4'd5}) begin
      fails++;
      $display("FAIL stall_hold got z%b v%b n%b res=%h rd=%h want 000 1234 5",
               flag_z, flag_v, flag_n, bus.mem_result, bus.mem_rd);
    end
    apply(0, 1, 1, 1, 4'b0001, 16'h0000, 1, 4'd6, 1, 1, 1, 16'h6666, 3'd7);
    tick();
    tests++;
    if ({bus.mem_valid, bus.mem_regwrite, bus.mem_memread, bus.mem_memwrite,
         flag_z, flag_v, flag_n, bus.mem_result} !== {7'b0, 16'h1234}) begin
      fails++;
      $display("FAIL flush_bubble got=%h want=%h", pack_dut(), pack_model());
    end
  endtask

  task automatic test_non_flag();
    apply(0, 0, 0, 1, 4'b1000, 16'h0000, 0, 4'd7, 1, 1, 0, 16'h7777, 3'd7);
    tick();
    tests++;
    if ({bus.mem_memread, flag_z} !== 2'b10) begin
      fails++;
      $display("FAIL load_no_flags got memread=%b z=%b want memread=1 z=0",
               bus.mem_memread, flag_z);
    end
    tests++;
    if (pack_dut() !== pack_model()) begin
      fails++;
      $display("FAIL load_state got=%h want=%h", pack_dut(), pack_model());
    end
  endtask

  task automatic test_branch_table();
    logic z, n, v;
    for (int f = 0; f < 8; f++) begin
      {z, n, v} = 3'(f);
      apply(0, 0, 0, 1, 4'b0000, n ? 16'h8000 : 16'h0001, v, 4'd1,
            0, 0, 0, 16'h0, 3'd7);
      tick();
      if (z) begin
        apply(0, 0, 0, 1, 4'b0010, 16'h0000, 0, 4'd1, 0, 0, 0, 16'h0, 3'd7);
        tick();
      end
      for (int c = 0; c < 8; c++) begin
        idle(3'(c));
        tests++;
        if (br_taken !== br_ref(3'(c), z, n, v)) begin
          fails++;
          $display("FAIL br_table z%b n%b v%b ccc=%0d got=%b want=%b",
                   z, n, v, c, br_taken, br_ref(3'(c), z, n, v));
        end
      end
    end
  endtask

  task automatic test_bypass();
    logic want;
    apply(0, 0, 0, 1, 4'b0000, 16'h0042, 0, 4'd2, 0, 0, 0, 16'h0, 3'd7);
    tick();
    apply(0, 0, 0, 1, 4'b0010, 16'h0000, 0, 4'd2, 1, 0, 0, 16'h0, 3'b001);
`ifdef FLAG_BYPASS_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    tests++;
    if (br_taken !== want) begin
      fails++;
      $display("FAIL bypass_same_cycle got=%b want=%b", br_taken, want);
    end
    tick();
    idle(3'b001);
    tests++;
    if (br_taken !== 1'b1) begin
      fails++;
      $display("FAIL bypass_next_cycle got=%b want=1", br_taken);
    end
  endtask

  task automatic test_random();
    logic [2:0] sf;
    logic [15:0] res;
    for (int i = 0; i < 400; i++) begin
      res = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom);
      apply($urandom_range(49) == 0, $urandom_range(6) == 0,
            $urandom_range(9) == 0, 1'($urandom), 4'($urandom_range(9)),
            res, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 16'($urandom), 3'($urandom));
      sf = src_flags();
      tests++;
      if (br_taken !== br_ref(br_ccc, sf[2], sf[0], sf[1])) begin
        fails++;
        $display("FAIL rand_br i=%0d ccc=%0d got=%b want=%b",
                 i, br_ccc, br_taken, br_ref(br_ccc, sf[2], sf[0], sf[1]));
      end
      tick();
      tests++;
      if (pack_dut() !== pack_model()) begin
        fails++;
        $display("FAIL rand_state i=%0d got=%h want=%h",
                 i, pack_dut(), pack_model());
      end
    end
  endtask

  initial begin
    {m_valid, m_rw, m_mr, m_mw, m_z, m_v, m_n} = '0;
    m_res = '0; m_rd = '0; m_sd = '0;
    apply(1, 0, 0, 0, 4'h0, 16'h0, 0, 4'h0, 0, 0, 0, 16'h0, 3'd7);
    @(negedge clk);
    test_reset();
    test_add_flags();
    test_stall_flush();
    test_non_flag();
    test_branch_table();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
